seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_if.sv | 17 +
 rtl/seg7_scan.sv | 121 ++++++++++++
 tb/tb_seg7_scan.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Display-side bundle for seg7_scan: the digit load strobe and its data in,
// the active-low anode/segment drives and the sticky error flag out.
interface seg7_scan_if;
  logic       load;
  logic [3:0] dec_in1;
  logic [3:0] dec_in2;
  logic [3:0] dec_in3;
  logic       blank_lz;
  logic [2:0] an;
  logic [6:0] seg;
  logic       err;

  modport master (output load, dec_in1, dec_in2, dec_in3, blank_lz,
                  input  an, seg, err);
  modport slave  (input  load, dec_in1, dec_in2, dec_in3, blank_lz,
                  output an, seg, err);
endinterface

// File: rtl/seg7_scan.sv
// Three-digit multiplexed 7-segment scanner with per-slot dark time,
// leading-zero blanking and a sticky invalid-digit flag.
//
// state | meaning
// IDLE  | display dark, waiting for the first load
// BLANK | start of a digit slot, all anodes off (ghosting guard)
// SHOW  | selected anode on, segments of digit idx driven
module seg7_scan #(
  parameter int unsigned CLK_DIV   = 1000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [15:0] CNT_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [3:0]  sh_hun;
  logic [3:0]  sh_ten;
  logic [3:0]  sh_one;
  logic        sh_blz;

  logic [3:0]  cur_dig;
  logic [6:0]  cur_seg;
  logic        blanked;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = 7'b0111111;
    endcase
  endfunction

  // Only an exact zero is blanked, so an invalid digit always shows its dash.
  always_comb begin
    cur_dig = sh_one;
    case (idx)
      2'd1:    cur_dig = sh_ten;
      2'd2:    cur_dig = sh_hun;
      default: cur_dig = sh_one;
    endcase
    cur_seg = encode(cur_dig);
    blanked = sh_blz &&
              (((idx == 2'd2) && (sh_hun == 4'd0)) ||
               ((idx == 2'd1) && (sh_hun == 4'd0) && (sh_ten == 4'd0)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh_hun   <= '0;
      sh_ten   <= '0;
      sh_one   <= '0;
      sh_blz   <= 1'b0;
      bus.an   <= 3'b111;
      bus.seg  <= 7'b1111111;
      bus.err  <= 1'b0;
    end else begin
      if ((state == SHOW) && !blanked) begin
        bus.an  <= ~(3'b001 << idx);
        bus.seg <= cur_seg;
      end else begin
        bus.an  <= 3'b111;
        bus.seg <= 7'b1111111;
      end

      // Shadows reload at any time; the scan position is never disturbed.
      if (bus.load) begin
        sh_hun  <= bus.dec_in1;
        sh_ten  <= bus.dec_in2;
        sh_one  <= bus.dec_in3;
        sh_blz  <= bus.blank_lz;
        bus.err <= (bus.dec_in1 > 4'd9) || (bus.dec_in2 > 4'd9) ||
                   (bus.dec_in3 > 4'd9);
      end

      case (state)
        IDLE: begin
          if (bus.load) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        BLANK: begin
          cnt <= cnt + 16'd1;
          if (cnt == BLANK_LAST) state <= SHOW;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            state <= BLANK;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: vector table of digit sets with their
// expected per-slot segment patterns, a timing model, and a scoreboard queue.
module tb_seg7_scan;
  localparam int CD = 8;
  localparam int BC = 2;
  localparam logic [6:0] DARK = 7'h7f;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_if bus ();
  seg7_scan #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0] d1, d2, d3;
    logic       blz;
    logic [6:0] s_one, s_ten, s_hun;
    logic       e;
  } vec_t;

  typedef struct {
    logic [2:0] an;
    logic [6:0] seg;
    logic       err;
  } exp_t;

  vec_t vecs[12];
  exp_t sbq[$];
  logic [2:0] an_of[3];
  int checks = 0;
  int failures = 0;

  bit   running = 1'b0;
  int   g = 0;
  int   cur = 0;
  logic e_m = 1'b0;

  task automatic step(input bit r, input bit ld, input int vi, input string tag);
    exp_t x;
    int slot, c;
    logic [6:0] s;
    rst = ~r;
    bus.load = ld;
    if (ld) begin
      bus.dec_in1  = vecs[vi].d1;
      bus.dec_in2  = vecs[vi].d2;
      bus.dec_in3  = vecs[vi].d3;
      bus.blank_lz = vecs[vi].blz;
    end
    x.an = 3'b111;
    x.seg = DARK;
    if (!r && running) begin
      slot = (g / CD) % 3;
      c = g % CD;
      if (c >= BC) begin
        s = (slot == 0) ? vecs[cur].s_one : (slot == 1) ? vecs[cur].s_ten : vecs[cur].s_hun;
        if (s != DARK) begin
          x.an = an_of[slot];
          x.seg = s;
        end
      end
    end
    if (r) begin
      running = 1'b0;
      e_m = 1'b0;
    end else if (ld) begin
      e_m = vecs[vi].e;
      cur = vi;
      if (!running) begin
        running = 1'b1;
        g = 0;
      end else begin
        g++;
      end
    end else if (running) begin
      g++;
    end
    x.err = e_m;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    checks++;
    if ({bus.an, bus.seg, bus.err} !== {x.an, x.seg, x.err}) begin
      failures++;
      $display("FAIL %s t=%0t an=%b seg=%b err=%b expected an=%b seg=%b err=%b",
               tag, $time, bus.an, bus.seg, bus.err, x.an, x.seg, x.err);
    end
    bus.load = 1'b0;
  endtask

  initial begin
    an_of[0] = 3'b110;
    an_of[1] = 3'b101;
    an_of[2] = 3'b011;
    //            hun    ten    one    blz   ones seg     tens seg     hund seg     err
    vecs[0]  = '{4'd1,  4'd9,  4'd0,  1'b0, 7'b1000000, 7'b0010000, 7'b1111001, 1'b0};
    vecs[1]  = '{4'd0,  4'd0,  4'd7,  1'b1, 7'b1111000, DARK,       DARK,       1'b0};
    vecs[2]  = '{4'd0,  4'd5,  4'd0,  1'b1, 7'b1000000, 7'b0010010, DARK,       1'b0};
    vecs[3]  = '{4'd12, 4'd3,  4'd4,  1'b0, 7'b0011001, 7'b0110000, 7'b0111111, 1'b1};
    vecs[4]  = '{4'd0,  4'd0,  4'd0,  1'b1, 7'b1000000, DARK,       DARK,       1'b0};
    vecs[5]  = '{4'd15, 4'd0,  4'd0,  1'b1, 7'b1000000, 7'b1000000, 7'b0111111, 1'b1};
    vecs[6]  = '{4'd2,  4'd8,  4'd6,  1'b0, 7'b0000010, 7'b0000000, 7'b0100100, 1'b0};
    vecs[7]  = '{4'd0,  4'd10, 4'd3,  1'b1, 7'b0110000, 7'b0111111, DARK,       1'b1};
    vecs[8]  = '{4'd0,  4'd0,  4'd5,  1'b0, 7'b0010010, 7'b1000000, 7'b1000000, 1'b0};
    vecs[9]  = '{4'd1,  4'd2,  4'd3,  1'b0, 7'b0110000, 7'b0100100, 7'b1111001, 1'b0};
    vecs[10] = '{4'd4,  4'd5,  4'd6,  1'b0, 7'b0000010, 7'b0010010, 7'b0011001, 1'b0};
    vecs[11] = '{4'd9,  4'd9,  4'd14, 1'b1, 7'b0111111, 7'b0010000, 7'b0010000, 1'b1};

    rst = 1'b0;
    bus.load = 1'b0;
    bus.dec_in1 = '0;
    bus.dec_in2 = '0;
    bus.dec_in3 = '0;
    bus.blank_lz = 1'b0;

    step(1, 0, 0, "reset_state");
    step(1, 0, 0, "reset_state");
    step(0, 0, 0, "idle_no_load");

    for (int i = 0; i < 12; i++) begin
      step(1, 0, i, "reset");
      step(0, 1, i, $sformatf("vec%0d_load", i));
      repeat (3 * CD + 4) step(0, 0, i, $sformatf("vec%0d_scan", i));
    end

    // Invalid load then clean load mid-scan: err must clear.
    step(1, 0, 0, "reset");
    step(0, 1, 3, "err_load");
    repeat (10) step(0, 0, 3, "err_scan");
    step(0, 1, 9, "err_clear_load");
    repeat (26) step(0, 0, 9, "err_clear_scan");

    // Reload during ones SHOW: scan timing continues unbroken.
    step(1, 0, 0, "reset");
    step(0, 1, 0, "reload_first");
    repeat (4) step(0, 0, 0, "reload_pre");
    step(0, 1, 10, "reload_mid");
    repeat (30) step(0, 0, 10, "reload_scan");

    // Reset during tens SHOW: dark next cycle, err cleared, stays dark.
    step(1, 0, 0, "reset");
    step(0, 1, 3, "midrst_load");
    repeat (12) step(0, 0, 3, "midrst_pre");
    step(1, 0, 3, "midrst_reset");
    repeat (20) step(0, 0, 3, "midrst_dark");

    // Reset wins over a simultaneous load.
    step(1, 0, 0, "reset");
    step(0, 1, 0, "prio_load");
    repeat (5) step(0, 0, 0, "prio_pre");
    step(1, 1, 6, "prio_rst_load");
    repeat (10) step(0, 0, 6, "prio_dark");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
